mult8x8_fold_sched: RTL and testbench

- Sequential 8x8 approximate multiplier controller that time-shares one external 4x4 sub-multiplier across the four quadrant partial products: LL, LH, HL, HH.
- Per operation it issues one quadrant per cycle, selects the approximate variant for each quadrant and accumulates the shifted partial products into a 16-bit result.
- Sits between a valid/ready operand stream and the shared 4x4 multiplier library cell. It replaces four parallel 4x4 instances plus a combiner.

---
 rtl/mult8x8_fold_sched.sv | 154 +++++++++++++++
 tb/tb_mult8x8_fold_sched.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mult8x8_fold_sched.sv
// Folded 8x8 approximate multiplier: issues one 4x4 quadrant per cycle to a shared
// sub-multiplier and accumulates the shifted partials. Optional macro FOLD_ZERO_SKIP_EN.
module mult8x8_fold_sched #(
  parameter bit         COMBINE = 1'b1,
  parameter logic [7:0] QSEL    = 8'hD6
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [3:0]  sub_a_o,
  output logic [3:0]  sub_b_o,
  output logic [1:0]  sub_sel_o,
  input  logic [7:0]  sub_r_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] r_o,
  output logic        busy_o
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // RUN   | one quadrant issued per cycle, q selects LL/LH/HL/HH
  // DONE  | result on r_o with out_valid high until out_ready
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [15:0] acc_q, acc_d, r_q, r_d;
  logic [1:0]  q_q, q_d;

  logic [15:0] partial, acc_next;
  logic [3:0]  qa, qb;

`ifdef FOLD_ZERO_SKIP_EN
  function automatic logic [3:0] nz_mask(input logic [7:0] a, input logic [7:0] b);
    nz_mask[0] = (|a[3:0]) & (|b[3:0]);
    nz_mask[1] = (|a[3:0]) & (|b[7:4]);
    nz_mask[2] = (|a[7:4]) & (|b[3:0]);
    nz_mask[3] = (|a[7:4]) & (|b[7:4]);
  endfunction

  // {found, index} of the first set mask bit at or above start
  function automatic logic [2:0] first_from(input logic [3:0] mask, input logic [2:0] start);
    first_from = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= start)) first_from = {1'b1, 2'(i)};
    end
  endfunction

  logic [2:0] nxt_in, nxt_run;
  always_comb begin
    nxt_in  = first_from(nz_mask(a_i, b_i), 3'd0);
    nxt_run = first_from(nz_mask(a_q, b_q), {1'b0, q_q} + 3'd1);
  end
`endif

  always_comb begin
    qa = q_q[1] ? a_q[7:4] : a_q[3:0];
    qb = q_q[0] ? b_q[7:4] : b_q[3:0];
    unique case (q_q)
      2'd0:    partial = {8'h00, sub_r_i};
      2'd3:    partial = {sub_r_i, 8'h00};
      default: partial = {4'h0, sub_r_i, 4'h0};
    endcase
    acc_next = COMBINE ? (acc_q | partial) : (acc_q + partial);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      q_q     <= q_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    r_d     = r_q;
    q_d     = q_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          acc_d   = '0;
          q_d     = '0;
          state_d = S_RUN;
`ifdef FOLD_ZERO_SKIP_EN
          if (nxt_in[2]) begin
            q_d = nxt_in[1:0];
          end else begin
            state_d = S_DONE;
            r_d     = '0;
          end
`endif
        end
      end
      S_RUN: begin
        acc_d = acc_next;
`ifdef FOLD_ZERO_SKIP_EN
        if (nxt_run[2]) begin
          q_d = nxt_run[1:0];
        end else begin
          state_d = S_DONE;
          r_d     = acc_next;
        end
`else
        if (q_q == 2'd3) begin
          state_d = S_DONE;
          r_d     = acc_next;
        end else begin
          q_d = q_q + 2'd1;
        end
`endif
      end
      S_DONE: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == S_IDLE);
    out_valid_o = (state_q == S_DONE);
    busy_o      = (state_q != S_IDLE);
    r_o         = r_q;
    sub_a_o     = '0;
    sub_b_o     = '0;
    sub_sel_o   = '0;
    if (state_q == S_RUN) begin
      sub_a_o   = qa;
      sub_b_o   = qb;
      sub_sel_o = QSEL[{q_q, 1'b0} +: 2];
    end
  end

endmodule

// File: tb/tb_mult8x8_fold_sched.sv
// Directed bench: two DUT copies (exact-add and OR combine) share stimulus; the
// shared sub-multiplier is modelled as an exact 4x4 product ignoring sub_sel.
module tb_mult8x8_fold_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready;
  logic [7:0] a, b;

  logic        ir0, ov0, busy0, ir1, ov1, busy1;
  logic [3:0]  sa0, sb0, sa1, sb1;
  logic [1:0]  ss0, ss1;
  logic [7:0]  sr0, sr1;
  logic [15:0] r0, r1;

  int n_pass = 0;
  int n_total = 0;
  logic [1:0] sel_log [8];

  always #5 clk = ~clk;

  assign sr0 = {4'h0, sa0} * {4'h0, sb0};
  assign sr1 = {4'h0, sa1} * {4'h0, sb1};

  mult8x8_fold_sched #(.COMBINE(1'b0), .QSEL(8'hD6)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir0),
    .a_i(a), .b_i(b), .sub_a_o(sa0), .sub_b_o(sb0), .sub_sel_o(ss0),
    .sub_r_i(sr0), .out_valid_o(ov0), .out_ready_i(out_ready), .r_o(r0), .busy_o(busy0));

  mult8x8_fold_sched #(.COMBINE(1'b1), .QSEL(8'hD6)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir1),
    .a_i(a), .b_i(b), .sub_a_o(sa1), .sub_b_o(sb1), .sub_sel_o(ss1),
    .sub_r_i(sr1), .out_valid_o(ov1), .out_ready_i(out_ready), .r_o(r1), .busy_o(busy1));

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r_add;
    logic [15:0] r_or;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  function automatic int nz_quads(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    if (x[3:0] != 0 && y[3:0] != 0) n++;
    if (x[3:0] != 0 && y[7:4] != 0) n++;
    if (x[7:4] != 0 && y[3:0] != 0) n++;
    if (x[7:4] != 0 && y[7:4] != 0) n++;
    return n;
  endfunction

  function automatic int exp_lat(input logic [7:0] x, input logic [7:0] y);
`ifdef FOLD_ZERO_SKIP_EN
    return nz_quads(x, y);
`else
    return 4;
`endif
  endfunction

  // Launch one op; lat = clock edges from accept to out_valid. With keep set,
  // in_valid stays high carrying different operands for the whole run.
  task automatic do_op(input logic [7:0] xa, input logic [7:0] xb, input bit keep,
                       output int lat, output int nsel);
    @(negedge clk);
    a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk);
    lat = 0; nsel = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (keep) begin
        a = 8'hFF; b = 8'hFF;
        check("in_ready_low_while_busy", {31'b0, ir0}, 32'd0);
      end else begin
        in_valid = 1'b0;
      end
      if (ov0) break;
      if (nsel < 8) sel_log[nsel] = ss0;
      nsel++;
      lat++;
    end
    in_valid = 1'b0;
    check("both_out_valid", {30'b0, ov0, ov1}, 32'd3);
  endtask

  task automatic finish_op(input logic [15:0] keep_r);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", {31'b0, ov0}, 32'd0);
    check("in_ready_back", {31'b0, ir0}, 32'd1);
    check("r_retained", {16'b0, r0}, {16'b0, keep_r});
  endtask

  initial begin
    automatic vec_t vecs[7];
    int lat, nsel;

    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01, 16'hEFF1};
    vecs[1] = '{8'h12, 8'h34, 16'h03A8, 16'h0368};
    vecs[2] = '{8'h03, 8'h05, 16'h000F, 16'h000F};
    vecs[3] = '{8'h00, 8'h00, 16'h0000, 16'h0000};
    vecs[4] = '{8'h0F, 8'h0F, 16'h00E1, 16'h00E1};
    vecs[5] = '{8'hF0, 8'h0F, 16'h0E10, 16'h0E10};
    vecs[6] = '{8'hA5, 8'h3C, 16'h26AC, 16'h1FFC};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
    #3;
    check("rst_in_ready", {31'b0, ir0}, 32'd1);
    check("rst_out_valid", {30'b0, ov0, ov1}, 32'd0);
    check("rst_busy", {31'b0, busy0}, 32'd0);
    check("rst_r", {r0, r1}, 32'd0);
    check("rst_sub", {22'b0, sa0, sb0, ss0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, 1'b0, lat, nsel);
      check($sformatf("latency_%0d", i), lat, exp_lat(vecs[i].a, vecs[i].b));
      check($sformatf("r_add_%0d", i), {16'b0, r0}, {16'b0, vecs[i].r_add});
      check($sformatf("r_or_%0d", i), {16'b0, r1}, {16'b0, vecs[i].r_or});
      if (i == 0) begin
        check("sel_count", nsel, 4);
        check("sel_seq", {24'b0, sel_log[0], sel_log[1], sel_log[2], sel_log[3]},
              {24'b0, 2'd2, 2'd1, 2'd1, 2'd3});
      end
      finish_op(vecs[i].r_add);
    end

    // Consumer stall in DONE
    do_op(8'hFF, 8'hFF, 1'b0, lat, nsel);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_out_valid", {31'b0, ov0}, 32'd1);
      check("stall_r", {16'b0, r0}, 32'h0000FE01);
      check("stall_in_ready", {31'b0, ir0}, 32'd0);
    end
    finish_op(16'hFE01);
    do_op(8'h03, 8'h05, 1'b0, lat, nsel);
    check("post_stall_r", {16'b0, r0}, 32'h0000000F);
    finish_op(16'h000F);

    // in_valid held with changing operands during the run
    do_op(8'h12, 8'h34, 1'b1, lat, nsel);
    check("keep_r_add", {16'b0, r0}, 32'h000003A8);
    check("keep_r_or", {16'b0, r1}, 32'h00000368);
    finish_op(16'h03A8);

    // Async reset at quadrant 2
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("pre_abort_busy", {31'b0, busy0}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'b0, ov0}, 32'd0);
    check("abort_busy", {31'b0, busy0}, 32'd0);
    check("abort_in_ready", {31'b0, ir0}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h03, 8'h05, 1'b0, lat, nsel);
    check("post_abort_r", {16'b0, r0}, 32'h0000000F);
    finish_op(16'h000F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
